// File: rtl/dircc_inbox_pkg.sv
// Shared types and helpers for the DiRCC node inbox writer.
package dircc_inbox_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        HEADER = 2'd2,
        DROP   = 2'd3
    } inbox_state_t;

    // Slot header word layout: {trunc, payload_len[14:0]}
    localparam int HDR_TRUNC_BIT = 15;
    localparam int HDR_LEN_MSB   = 14;

    // One registered write on the processing-memory port
    typedef struct packed {
        logic        we;
        logic [14:0] addr;
        logic [15:0] data;
    } mem_wr_t;

    // Word address of word 0 of a slot in the 15-bit memory space
    function automatic logic [14:0] slot_base(input int base, input int slot_words, input int slot);
        int a;
        a = base + slot * slot_words;
        return a[14:0];
    endfunction

endpackage

// File: rtl/dircc_inbox_slot_counter.sv
// Slot occupancy tracking: count of full slots, the one-cycle commit delay
// and the ring-full flag seen by the writer.
module dircc_inbox_slot_counter #(
    parameter int NUM_SLOTS = 8,
    parameter int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             commit,
    input  logic             slot_release,
    output logic [CNT_W-1:0] count,
    output logic             commit_pending,
    output logic             full
);

    logic           rel_ok;
    logic [CNT_W:0] occ;

    // A release with nothing pending refers to no slot and is dropped
    assign rel_ok = slot_release && (count != '0);

    // A slot being committed is already owned, so it counts toward full
    assign occ  = {1'b0, count} + {{CNT_W{1'b0}}, commit_pending};
    assign full = (occ == (CNT_W + 1)'(NUM_SLOTS));

    // Count lags the header write by one cycle; commit+release cancel out
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count          <= '0;
            commit_pending <= 1'b0;
        end else begin
            commit_pending <= commit;
            if (commit_pending && !rel_ok)
                count <= count + CNT_W'(1);
            else if (!commit_pending && rel_ok)
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/dircc_node_inbox_writer.sv
// Inbound packet writer: streams receive-port packets into a ring of
// fixed-size slots in processing memory, writes a header word last and then
// publishes the slot to the CPU through pending_count.
// Optional: define DIRCC_INBOX_IRQ_EN to build a level interrupt that is high
// while any slot is pending; otherwise irq is tied low.
module dircc_node_inbox_writer
    import dircc_inbox_pkg::*;
#(
    parameter int BASE_ADDR  = 16384,
    parameter int SLOT_WORDS = 32,
    parameter int NUM_SLOTS  = 8,
    parameter int CNT_W      = $clog2(NUM_SLOTS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic [14:0]      mem_address,
    output logic [15:0]      mem_writedata,
    output logic [1:0]       mem_byteenable,
    output logic             mem_chipselect,
    output logic             mem_write,
    output logic             mem_clken,
    input  logic             slot_release,
    output logic [CNT_W-1:0] pending_count,
    output logic             overflow_sticky,
    output logic             irq
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int IDX_W  = $clog2(SLOT_WORDS) + 1;   // must hold SLOT_WORDS
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOT_WORDS - 1);

    inbox_state_t      state_q, state_d;
    logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic              trunc_q, trunc_d;
    mem_wr_t           mem_q, mem_d;
    logic              commit;
    logic              commit_pending;
    logic              full;
    logic [14:0]       base_addr;
    logic [15:0]       hdr;

    dircc_inbox_slot_counter #(
        .NUM_SLOTS (NUM_SLOTS),
        .CNT_W     (CNT_W)
    ) u_slot_counter (
        .clk            (clk),
        .reset_n        (reset_n),
        .commit         (commit),
        .slot_release   (slot_release),
        .count          (pending_count),
        .commit_pending (commit_pending),
        .full           (full)
    );

    assign base_addr      = slot_base(BASE_ADDR, SLOT_WORDS, int'(wr_slot_q));
    assign mem_write      = mem_q.we;
    assign mem_chipselect = mem_q.we;
    assign mem_address    = mem_q.addr;
    assign mem_writedata  = mem_q.data;
    assign mem_byteenable = 2'b11;
    assign mem_clken      = 1'b1;

    // Next-state, handshake and next memory write
    always_comb begin
        state_d    = state_q;
        wr_slot_d  = wr_slot_q;
        word_idx_d = word_idx_q;
        trunc_d    = trunc_q;
        mem_d      = mem_q;
        mem_d.we   = 1'b0;
        commit     = 1'b0;
        in_ready   = 1'b0;
        hdr        = '0;
        case (state_q)
            IDLE: begin
                in_ready = reset_n && !full;
                // Stray mid-packet beats are swallowed without a write
                if (in_valid && in_ready && in_sop) begin
                    mem_d.we   = 1'b1;
                    mem_d.addr = base_addr + 15'd1;
                    mem_d.data = in_data;
                    word_idx_d = IDX_W'(2);
                    trunc_d    = 1'b0;
                    state_d    = in_eop ? HEADER : DATA;
                end
            end
            DATA: begin
                in_ready = reset_n;
                if (in_valid && in_ready) begin
                    mem_d.we   = 1'b1;
                    mem_d.addr = base_addr + {{(15 - IDX_W){1'b0}}, word_idx_q};
                    mem_d.data = in_data;
                    word_idx_d = word_idx_q + IDX_W'(1);
                    if (in_eop) begin
                        state_d = HEADER;
                    end else if (word_idx_q == LAST_IDX) begin
                        state_d = DROP;
                        trunc_d = 1'b1;
                    end
                end
            end
            DROP: begin
                in_ready = reset_n;
                if (in_valid && in_ready && in_eop)
                    state_d = HEADER;
            end
            HEADER: begin
                // word_idx points one past the last stored payload word
                hdr[HDR_TRUNC_BIT]    = trunc_q;
                hdr[HDR_LEN_MSB:0]    = {{(HDR_LEN_MSB + 1 - IDX_W){1'b0}}, word_idx_q - IDX_W'(1)};
                mem_d.we   = 1'b1;
                mem_d.addr = base_addr;
                mem_d.data = hdr;
                commit     = 1'b1;
                wr_slot_d  = wr_slot_q + SLOT_W'(1);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Writer state and registered memory port
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_slot_q  <= '0;
            word_idx_q <= '0;
            trunc_q    <= 1'b0;
            mem_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_slot_q  <= wr_slot_d;
            word_idx_q <= word_idx_d;
            trunc_q    <= trunc_d;
            mem_q      <= mem_d;
        end
    end

    // Sticky flag latches any truncated packet as its header goes out
    always_ff @(posedge clk) begin
        if (!reset_n)
            overflow_sticky <= 1'b0;
        else if (state_q == HEADER && trunc_q)
            overflow_sticky <= 1'b1;
    end

`ifdef DIRCC_INBOX_IRQ_EN
    // Level interrupt while the CPU has slots to drain
    always_ff @(posedge clk) begin
        if (!reset_n)
            irq <= 1'b0;
        else
            irq <= (pending_count != '0);
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: doc/dircc_node_inbox_writer.md
# dircc_node_inbox_writer

Inbound message writer for a DiRCC processing node. Consumes 16-bit packets from the node's network receive port and deposits them, via the 16-bit second port of the node's processing memory, into a fixed ring of message slots. It maintains slot occupancy for the Nios core, which drains slots and releases them. It applies back-pressure when the ring is full and never drops a packet for lack of space.

## Interface
- `BASE_ADDR`, default 16384: 16-bit-word address of slot 0 in processing memory (15-bit space).
- `SLOT_WORDS`, default 32: 16-bit words per slot. Word 0 is the header; up to `SLOT_WORDS-1` words are payload. Power of two, at least 4.
- `NUM_SLOTS`, default 8: slots in the ring. Power of two, at least 2.
- `CNT_W`, default `$clog2(NUM_SLOTS+1)`: width of the occupancy count.

Ports:
- `clk` in 1: sole clock.
- `reset_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: receive beat valid.
- `in_ready` out 1: block accepts the beat. A transfer occurs when `in_valid & in_ready`.
- `in_data` in 16: payload word.
- `in_sop` in 1: first beat of a packet.
- `in_eop` in 1: last beat of a packet.
- `mem_address` out 15: word address on the memory's 16-bit port.
- `mem_writedata` out 16: write data.
- `mem_byteenable` out 2: constant `2'b11`.
- `mem_chipselect` out 1: asserted together with `mem_write`.
- `mem_write` out 1: single-cycle write strobe. The memory never stalls.
- `mem_clken` out 1: constant 1.
- `slot_release` in 1: one-cycle pulse from the CPU CSR. The oldest full slot has been consumed.
- `pending_count` out `CNT_W`: number of full, unreleased slots.
- `overflow_sticky` out 1: a truncated packet has been committed since reset.
- `irq` out 1: see Configuration.

## Operation
- The FSM has four states: `IDLE`, `DATA`, `HEADER`, `DROP`.
- **IDLE:**
  - `in_ready = !full`, where `full = (pending_count + commit_pending == NUM_SLOTS)`.
  - An accepted beat with `in_sop` is written to payload word 1 of slot `wr_slot`.
    - If it also carries `in_eop`, go to `HEADER`.
    - Otherwise go to `DATA`.
  - An accepted beat without `in_sop` is discarded with no write.
- **DATA:** `in_ready = 1`.
  - Each beat is written at `slot_base + word_idx`, and `word_idx` increments.
  - `in_sop` is ignored here; the beat is treated as data.
  - `in_eop` goes to `HEADER`.
  - If the slot fills (`word_idx == SLOT_WORDS-1` is written) without `eop`, go to `DROP` and set `trunc`.
- **DROP:** `in_ready = 1`. Beats are discarded. `in_eop` goes to `HEADER`.
- **HEADER:** `in_ready = 0`.
  - Write word 0 of the slot: `{trunc, payload_len[14:0]}`, where `payload_len` is the number of stored payload words.
  - Set `commit_pending`, advance `wr_slot` modulo `NUM_SLOTS`, and go to `IDLE`.
- Slot base address is `BASE_ADDR + wr_slot*SLOT_WORDS`.
- `pending_count`:
  - Increments one cycle after the header write.
  - Decrements on `slot_release`.
  - Commit and release in the same cycle leave it unchanged.
  - `slot_release` at a count of 0 is ignored.
- A committed `trunc` sets `overflow_sticky`, which only reset clears.

## Timing
- All `mem_*` outputs are registered. A beat accepted in cycle N is written in cycle N+1.
- For an `eop` accepted in cycle N:
  - N+1: last payload write on the bus; FSM is in `HEADER`, `in_ready = 0`.
  - N+2: header write on the bus; FSM is in `IDLE`.
  - N+3: `pending_count` incremented, so the CPU sees a slot only after its header is in memory.
- Sustained throughput is one beat per cycle, plus one bubble per packet.
- Reset values: `mem_write`, `mem_chipselect` = 0; `mem_address`, `mem_writedata` = 0; `pending_count` = 0; `overflow_sticky` = 0; `irq` = 0; FSM in `IDLE`; `wr_slot` = 0.
- `in_ready` is 0 during reset.
- Reset mid-packet abandons the partial slot: no header write, no count change.

## Configuration
- `DIRCC_INBOX_IRQ_EN` defined: `irq` is registered high while `pending_count != 0`.
- Not defined: `irq` is tied to 0 and no interrupt logic is built. Software polls `pending_count`.

## Structure
- Package `dircc_inbox_pkg` holds:
  - the state enum;
  - header bit positions (`HDR_TRUNC_BIT = 15`, `HDR_LEN_MSB = 14`);
  - a function for slot base address.
- Sub-module `dircc_inbox_slot_counter` holds the occupancy counter, `commit_pending` and the `full` flag, including the simultaneous commit/release rule.

## Test plan
- 3-word packet `A1,A2,A3` (sop on A1, eop on A3) with defaults:
  - writes at 16385, 16386, 16387;
  - header `0x0003` at 16384;
  - `pending_count` reaches 1 at eop+3.
- 40-word packet into a 32-word slot:
  - 31 payload writes;
  - 9 beats accepted and discarded;
  - header `0x801F`;
  - `overflow_sticky = 1`.
- Nine 1-word packets with no release:
  - the 8th fills slot 7 (header at 16608);
  - the 9th sop is held with `in_ready = 0`;
  - one `slot_release` lets it land in slot 0 (header at 16384).
- Commit and `slot_release` in the same cycle at count 3: count stays 3. Release at count 0: count stays 0.
- `reset_n` low during the 2nd beat of a 5-word packet:
  - no header write;
  - count 0, FSM in `IDLE`;
  - the next packet goes to slot 0.
- Non-sop beat in `IDLE`: accepted with no memory write. With `DIRCC_INBOX_IRQ_EN` defined, `irq` tracks `pending_count != 0`.
